// File: rtl/spi_host_arbiter.sv
// spi_host_arbiter: round-robin ownership arbiter for one shared SPI host.
// A requester owns the host and its latched chip select for a whole
// transaction. The owner gives the bus back by releasing, by dropping its
// request, or by being revoked after a long idle stretch. The chip select
// stays low until the host drains, and IDLE always lasts at least one cycle
// between two owners.
module spi_host_arbiter #(
    parameter int NReq          = 4,
    parameter int CsNum         = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NReq-1:0]                   req_i,
    input  logic [NReq-1:0]                   rel_i,
    input  logic [NReq*$clog2(CsNum)-1:0]     cs_sel_i,
    input  logic                              host_idle_i,
    output logic [NReq-1:0]                   gnt_o,
    output logic [$clog2(NReq)-1:0]           owner_o,
    output logic                              busy_o,
    output logic [CsNum-1:0]                  cs_no,
    output logic                              timeout_o
);

    localparam int OwnW = $clog2(NReq);
    localparam int SelW = $clog2(CsNum);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_r, state_s;
    logic [NReq-1:0]      gnt_r, gnt_s;
    logic [OwnW-1:0]      owner_r, owner_s;
    logic [SelW-1:0]      sel_r, sel_s;
    logic [CsNum-1:0]     cs_r, cs_s;
    logic                 busy_r, busy_s;
    logic                 timeout_r, timeout_s;
    logic [OwnW-1:0]      ptr_r, ptr_s;
    logic [CntW-1:0]      cnt_r, cnt_s;

    logic [OwnW-1:0]      pick_s;
    logic [SelW-1:0]      pick_sel_s;
    logic                 owner_rel_s;
    logic                 owner_drop_s;
    logic                 expire_s;

    // First requesting index at or after ptr, wrapping modulo NReq.
    function automatic logic [OwnW-1:0] rr_pick(input logic [NReq-1:0] req,
                                                input logic [OwnW-1:0] ptr);
        logic [OwnW-1:0] pick;
        logic            found;
        logic            hit;
        int              k;
        pick  = {OwnW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NReq; i++) begin
            k     = (int'(ptr) + i) % NReq;
            hit   = req[k[OwnW-1:0]] & ~found;
            pick  = hit ? k[OwnW-1:0] : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    // Index following idx, wrapping modulo NReq.
    function automatic logic [OwnW-1:0] next_idx(input logic [OwnW-1:0] idx);
        int k;
        k = (int'(idx) + 1) % NReq;
        return k[OwnW-1:0];
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NReq-1:0] onehot(input logic [OwnW-1:0] idx);
        logic [NReq-1:0] v;
        v      = {NReq{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Active-low chip-select pattern with only line sel asserted.
    function automatic logic [CsNum-1:0] cs_decode(input logic [SelW-1:0] sel);
        logic [CsNum-1:0] v;
        v      = {CsNum{1'b1}};
        v[sel] = 1'b0;
        return v;
    endfunction

    assign pick_s       = rr_pick(req_i, ptr_r);
    assign pick_sel_s   = cs_sel_i[pick_s*SelW +: SelW];
    assign owner_rel_s  = rel_i[owner_r];
    assign owner_drop_s = ~req_i[owner_r];
    assign expire_s     = host_idle_i & (cnt_r == CntW'(TimeoutCycles - 1));

    // Next-state and next-output computation for the ownership FSM.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        owner_s   = owner_r;
        sel_s     = sel_r;
        cs_s      = cs_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    state_s = ST_GRANT;
                    gnt_s   = onehot(pick_s);
                    owner_s = pick_s;
                    sel_s   = pick_sel_s;
                    cs_s    = cs_decode(pick_sel_s);
                    busy_s  = 1'b1;
                    ptr_s   = next_idx(pick_s);
                    cnt_s   = {CntW{1'b0}};
                end else begin
                    gnt_s  = {NReq{1'b0}};
                    cs_s   = {CsNum{1'b1}};
                    busy_s = 1'b0;
                    cnt_s  = {CntW{1'b0}};
                end
            end
            ST_GRANT: begin
                // A release takes precedence over a coincident expiry.
                if (owner_rel_s || owner_drop_s) begin
                    state_s = ST_DRAIN;
                    gnt_s   = {NReq{1'b0}};
                end else if (expire_s) begin
                    state_s   = ST_DRAIN;
                    gnt_s     = {NReq{1'b0}};
                    timeout_s = 1'b1;
                end else if (host_idle_i) begin
                    cnt_s = cnt_r + CntW'(1);
                end else begin
                    cnt_s = {CntW{1'b0}};
                end
            end
            ST_DRAIN: begin
                // Keep the chip select low until the host has finished.
                if (host_idle_i) begin
                    state_s = ST_IDLE;
                    cs_s    = {CsNum{1'b1}};
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NReq{1'b0}};
                cs_s    = {CsNum{1'b1}};
                busy_s  = 1'b0;
                cnt_s   = {CntW{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, latched selection, priority pointer and idle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_r     <= {NReq{1'b0}};
            owner_r   <= {OwnW{1'b0}};
            sel_r     <= {SelW{1'b0}};
            cs_r      <= {CsNum{1'b1}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            ptr_r     <= {OwnW{1'b0}};
            cnt_r     <= {CntW{1'b0}};
        end else begin
            gnt_r     <= gnt_s;
            owner_r   <= owner_s;
            sel_r     <= sel_s;
            cs_r      <= cs_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
        end
    end

    assign gnt_o     = gnt_r;
    assign owner_o   = owner_r;
    assign busy_o    = busy_r;
    assign cs_no     = cs_r;
    assign timeout_o = timeout_r;

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Testbench for spi_host_arbiter: directed scenarios followed by a random
// phase, every cycle compared against a transaction-level reference model.
module tb_spi_host_arbiter;

    localparam int NREQ = 4;
    localparam int CSN  = 4;
    localparam int TMO  = 16;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [7:0] cs_sel;
    logic       host_idle;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] cs_n;
    logic       tmo;

    int n_checks;
    int n_fail;

    // Reference model: who holds the bus, whether it is draining, and how
    // many consecutive idle cycles the current owner has accumulated.
    bit m_granted;
    bit m_draining;
    bit m_tmo;
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_run;

    int gap;
    int budget;
    int pulses;
    int first_at;

    spi_host_arbiter #(
        .NReq(NREQ),
        .CsNum(CSN),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req),
        .rel_i(rel),
        .cs_sel_i(cs_sel),
        .host_idle_i(host_idle),
        .gnt_o(gnt),
        .owner_o(owner),
        .busy_o(busy),
        .cs_no(cs_n),
        .timeout_o(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_granted  = 1'b0;
        m_draining = 1'b0;
        m_tmo      = 1'b0;
        m_owner    = 0;
        m_sel      = 0;
        m_ptr      = 0;
        m_run      = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        m_tmo = 1'b0;
        if (m_granted) begin
            if (rel[m_owner] || !req[m_owner]) begin
                m_granted  = 1'b0;
                m_draining = 1'b1;
            end else if (host_idle) begin
                m_run++;
                if (m_run == TMO) begin
                    m_granted  = 1'b0;
                    m_draining = 1'b1;
                    m_tmo      = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_draining) begin
            if (host_idle) m_draining = 1'b0;
        end else if (req != 4'b0000) begin
            for (int off = 0; off < NREQ; off++) begin
                int c;
                c = (m_ptr + off) % NREQ;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_sel     = (cs_sel >> (2 * m_owner)) & 3;
            m_ptr     = (m_owner + 1) % NREQ;
            m_granted = 1'b1;
            m_run     = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        logic [3:0] ec;
        eg = 4'b0000;
        ec = 4'b1111;
        if (m_granted) eg[m_owner] = 1'b1;
        if (m_granted || m_draining) ec[m_sel] = 1'b0;
        check({tag, "_gnt"}, gnt, eg);
        check({tag, "_cs"}, cs_n, ec);
        check({tag, "_owner"}, owner, m_owner);
        check({tag, "_busy"}, busy, m_granted || m_draining);
        check({tag, "_timeout"}, tmo, m_tmo);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        rel       = 4'b0000;
        cs_sel    = 8'b00_01_10_11;
        host_idle = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("por");
        check("por_cs", cs_n, 4'b1111);
        check("por_gnt", gnt, 4'b0000);

        // Single requester 2 (chip select 1).
        req = 4'b0100;
        tick("single");
        check("single_gnt", gnt, 4'b0100);
        check("single_cs", cs_n, 4'b1101);
        rel = 4'b0100;
        tick("single_rel");
        rel = 4'b0000;
        req = 4'b0000;
        check("single_drain_gnt", gnt, 4'b0000);
        check("single_drain_cs", cs_n, 4'b1101);
        tick("single_idle");
        check("single_idle_cs", cs_n, 4'b1111);
        check("single_idle_busy", busy, 1'b0);

        // Round-robin fairness from a fresh pointer.
        apply_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            gap    = 0;
            budget = 0;
            while (gnt == 4'b0000 && budget < 10) begin
                tick("rr");
                budget++;
                if (cs_n == 4'b1111) gap++;
            end
            check("rr_grant_seen", gnt != 4'b0000, 1);
            check("rr_order", owner, g % 4);
            if (g > 0) check("rr_gap", gap >= 1, 1);
            rel = gnt;
            tick("rr_rel");
            rel = 4'b0000;
        end
        req = 4'b0000;
        tick("rr_end");
        tick("rr_end");

        // Drain hold: host busy for 5 cycles after release.
        req = 4'b0001;
        tick("drain_grant");
        check("drain_grant_gnt", gnt, 4'b0001);
        host_idle = 1'b0;
        rel       = 4'b0001;
        tick("drain_rel");
        rel = 4'b0000;
        req = 4'b0000;
        check("drain_gnt", gnt, 4'b0000);
        check("drain_cs0", cs_n, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            tick("drain_hold");
            check("drain_cs_hold", cs_n, 4'b0111);
        end
        host_idle = 1'b1;
        tick("drain_done");
        check("drain_done_cs", cs_n, 4'b1111);

        // Timeout with a permanently idle host.
        req = 4'b0010;
        tick("tmo_grant");
        pulses   = 0;
        first_at = 0;
        for (int t = 1; t <= 17; t++) begin
            tick("tmo");
            if (tmo) begin
                pulses++;
                if (first_at == 0) first_at = t;
            end
        end
        check("tmo_first_at", first_at, 16);
        check("tmo_pulses", pulses, 1);
        check("tmo_cs_released", cs_n, 4'b1111);
        req = 4'b0000;
        tick("tmo_end");

        // Timeout restarted by a busy host at cycle 10.
        req = 4'b0010;
        tick("tmo2_grant");
        pulses   = 0;
        first_at = 0;
        for (int t = 1; t <= 27; t++) begin
            host_idle = (t == 10) ? 1'b0 : 1'b1;
            tick("tmo2");
            if (tmo) begin
                pulses++;
                if (first_at == 0) first_at = t;
            end
        end
        check("tmo2_first_at", first_at, 26);
        check("tmo2_pulses", pulses, 1);
        req = 4'b0000;
        tick("tmo2_end");

        // Non-owner release ignored; owner release coincident with expiry.
        req = 4'b0001;
        tick("co_grant");
        rel = 4'b1110;
        tick("co_nonowner");
        rel = 4'b0000;
        check("nonowner_gnt", gnt, 4'b0001);
        for (int t = 2; t <= 15; t++) tick("co_wait");
        rel = 4'b0001;
        tick("co_rel");
        rel = 4'b0000;
        check("co_timeout", tmo, 1'b0);
        check("co_gnt", gnt, 4'b0000);
        check("co_busy", busy, 1'b1);
        req = 4'b0000;
        tick("co_end");

        // Owner dropping its request acts as a release.
        req = 4'b1000;
        tick("drop_grant");
        check("drop_grant_gnt", gnt, 4'b1000);
        req = 4'b0000;
        tick("drop");
        check("drop_gnt", gnt, 4'b0000);
        check("drop_busy", busy, 1'b1);
        tick("drop_idle");
        check("drop_idle_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a grant.
        req = 4'b1000;
        tick("ar_grant");
        #2;
        rst = 1'b1;
        #1;
        check("ar_cs", cs_n, 4'b1111);
        check("ar_gnt", gnt, 4'b0000);
        check("ar_busy", busy, 1'b0);
        model_reset();
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("ar_release");
        req = 4'b1010;
        tick("ar_regrant");
        check("ar_regrant_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick("ar_end");
        tick("ar_end");

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rel       = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            host_idle = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) cs_sel = 8'($urandom);
            tick("rand");
            rel = 4'b0000;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
